// File: rtl/dff_d_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : dff_d_conditioner_if
//  Description : Signal bundle between a raw asynchronous level source and
//                the dff_d_conditioner that synchronizes and debounces it.
//
//  Signals
//    din   raw asynchronous level (switch or external pin)
//    dout  synchronized, debounced level (drives a downstream flop d input)
//    rise  one-cycle pulse when dout goes 0->1
//    fall  one-cycle pulse when dout goes 1->0
//    busy  a candidate level change is currently being qualified
//
//  Modports
//    master  : the side that supplies din and observes the conditioned level
//    slave   : the conditioner itself
//
//  Revision    : 1.0  initial release
// ============================================================================
interface dff_d_conditioner_if;

    logic din;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output din,
        input  dout,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  din,
        output dout,
        output rise,
        output fall,
        output busy
    );

endinterface : dff_d_conditioner_if
`default_nettype wire

// File: rtl/dff_d_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : dff_d_conditioner
//  Description : Conditions a raw asynchronous level (switch, external pin)
//                before it feeds the d input of a flip-flop. The level is
//                first passed through a SYNC_STAGES-deep synchronizer and
//                then debounced: the output only follows the synchronized
//                level after it has differed from the current output for
//                STABLE_CYCLES consecutive clocks. Shorter excursions are
//                discarded. Every output is a flop; nothing combinational
//                runs from din to any output.
//
//  Parameters
//    SYNC_STAGES    synchronizer depth, 2..4                    (default 2)
//    CNT_W          stability counter width                     (default 8)
//    STABLE_CYCLES  qualification length, 2..2**CNT_W           (default 16)
//
//  Ports
//    clk    single clock, all state updates on its rising edge
//    reset  asynchronous, active-high; clears every flop immediately
//    bus    dff_d_conditioner_if.slave
//             din  (in)  raw level
//             dout (out) debounced level
//             rise (out) one-cycle pulse on dout 0->1
//             fall (out) one-cycle pulse on dout 1->0
//             busy (out) high while the stability counter is non-zero
//
//  Latency     : dout changes SYNC_STAGES+STABLE_CYCLES-1 edges after the
//                edge that first captures a new, thereafter stable, level.
//
//  Build option: DFF_D_CONDITIONER_EDGE_EN
//                defined   -> rise/fall are registered edge pulses
//                undefined -> rise/fall are tied to 0 and no pulse flops
//                             exist; dout and busy are unaffected
//
//  Revision    : 1.0  initial release
// ============================================================================
module dff_d_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 8,
    parameter int STABLE_CYCLES = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    dff_d_conditioner_if.slave     bus
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync_stages
        $error("dff_d_conditioner: SYNC_STAGES must be in 2..4");
    end

    if ((STABLE_CYCLES < 2) || (STABLE_CYCLES > (2 ** CNT_W))) begin : g_bad_stable_cycles
        $error("dff_d_conditioner: STABLE_CYCLES must be in 2..2**CNT_W");
    end

    // Terminal counter value: reaching it with a still-differing level means
    // the candidate has been stable for STABLE_CYCLES edges in a row.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Synchronizer. r_sync[0] is the only flop that ever samples din; the
    // debouncer below only ever looks at the last stage.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.din};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Debouncer state
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_dout;
    logic             w_dout_nxt;
    logic             w_update;
    logic             r_busy;

    // The counter only advances while the synchronized level disagrees with
    // dout. Any agreement (glitch ended) drops it straight back to zero, so a
    // qualification restarts from scratch. On the terminal count the level
    // is accepted and the counter clears on the same edge, which also means
    // it can never run past c_cnt_last and wrap.
    always_comb begin
        w_cnt_nxt = '0;
        w_update  = 1'b0;
        if (w_s != r_dout) begin
            if (r_cnt == c_cnt_last) begin
                w_update = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    assign w_dout_nxt = w_update ? w_s : r_dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_dout <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_dout <= w_dout_nxt;
            // Built from the next counter value so that busy is a flop and
            // still equals (r_cnt != 0) on every cycle.
            r_busy <= (w_cnt_nxt != '0);
        end
    end

    assign bus.dout = r_dout;
    assign bus.busy = r_busy;

    // ------------------------------------------------------------------------
    // Edge pulses. Registered on the very edge that dout changes, so they are
    // aligned with the new dout value and last exactly one cycle. Only one of
    // them can be set on a given edge because w_s selects which.
    // ------------------------------------------------------------------------
`ifdef DFF_D_CONDITIONER_EDGE_EN
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_update &  w_s;
            r_fall <= w_update & ~w_s;
        end
    end

    assign bus.rise = r_rise;
    assign bus.fall = r_fall;
`else
    assign bus.rise = 1'b0;
    assign bus.fall = 1'b0;
`endif

endmodule : dff_d_conditioner
`default_nettype wire
